// File: rtl/byte_packer.sv
// byte_packer: gathers RATIO IN_W-bit beats into one word with keep mask, last/flush close
// and an optional idle-timeout flush enabled by BYTE_PACKER_TIMEOUT_EN.
module byte_packer #(
  parameter int IN_W        = 8,
  parameter int RATIO       = 2,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [IN_W-1:0]       i_data,
  input  logic                  i_last,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [RATIO*IN_W-1:0] o_data,
  output logic [RATIO-1:0]      o_keep,
  output logic                  o_last
);
  localparam int OW = RATIO * IN_W;
  localparam int CW = $clog2(RATIO);
  logic [CW-1:0]    cnt_q, cnt_d, lane;
  logic [OW-1:0]    acc_q, acc_d, acc_nx, data_q, data_d;
  logic [RATIO-1:0] akeep_q, akeep_d, akeep_nx, keep_q, keep_d;
  logic             valid_q, valid_d, last_q, last_d, pend_q, pend_d;
  logic             out_free, take, full, flush_req, close_beat, flush_nb, load_flush, tmo;
  assign out_free   = !valid_q || i_ready;
  assign o_ready    = out_free && !pend_q;
  assign take       = i_valid && o_ready;
  assign lane       = MSB_FIRST ? CW'(RATIO - 1) - cnt_q : cnt_q;
  assign acc_nx     = acc_q | (OW'(i_data) << (int'(lane) * IN_W));
  assign akeep_nx   = akeep_q | (RATIO'(1) << lane);
  assign full       = cnt_q == CW'(RATIO - 1);
  assign flush_req  = i_flush || tmo;
  assign close_beat = take && (full || i_last || flush_req);
  // a flush without a beat waits in pend_q until the output register can take it
  assign flush_nb   = !take && cnt_q != '0 && (flush_req || pend_q);
  assign load_flush = flush_nb && out_free;
  always_comb begin
    cnt_d   = (close_beat || load_flush) ? '0 : take ? cnt_q + 1'b1 : cnt_q;
    acc_d   = (close_beat || load_flush) ? '0 : take ? acc_nx : acc_q;
    akeep_d = (close_beat || load_flush) ? '0 : take ? akeep_nx : akeep_q;
    valid_d = close_beat || load_flush || (valid_q && !i_ready);
    data_d  = close_beat ? acc_nx : load_flush ? acc_q : data_q;
    keep_d  = close_beat ? akeep_nx : load_flush ? akeep_q : keep_q;
    last_d  = close_beat ? i_last : load_flush ? 1'b0 : last_q;
    pend_d  = flush_nb && !out_free;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      akeep_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      akeep_q <= akeep_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end
`ifdef BYTE_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_q, idle_d;
  assign tmo = idle_q == TW'(TIMEOUT_CYC);
  always_comb idle_d = (tmo || take || cnt_q == '0) ? '0 : pend_q ? idle_q : idle_q + 1'b1;
  always_ff @(posedge i_clk) idle_q <= i_rst ? '0 : idle_d;
`else
  assign tmo = 1'b0;
`endif
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_keep  = keep_q;
  assign o_last  = last_q;
endmodule

// File: doc/byte_packer.md
# byte_packer

Parametrised width-upsizing packer: gathers `RATIO` consecutive `IN_W`-bit beats from the UART receive path into one `RATIO*IN_W`-bit word for the FIFO/DDR write path. It adds the following:
- ready/valid backpressure on both sides;
- selectable lane order;
- partial-word emission on `i_last` or `i_flush`, with a per-lane keep mask;
- an optional idle timeout flush.

Full-rate: one input beat accepted per cycle when downstream is ready.

## Interface
- `IN_W`, 8, input beat width in bits.
- `RATIO`, 2, input beats per output word; legal values are ≥2.
- `MSB_FIRST`, 1:
  - 1 places the first beat in the most-significant lane.
  - 0 places the first beat in lane 0 (LSBs).
- `TIMEOUT_CYC`, 1024, idle cycles before an automatic flush. Used only when `BYTE_PACKER_TIMEOUT_EN` is defined; must be ≥1.
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rst`  in  1  synchronous reset, active-high.
- `i_valid`  in  1  input beat valid.
- `o_ready`  out  1  packer can accept a beat; combinational from `i_ready`.
- `i_data`  in  `IN_W`  input beat.
- `i_last`  in  1  beat closes the current word, even if it is partial.
- `i_flush`  in  1  one-cycle request to emit any buffered partial word.
- `o_valid`  out  1  output word valid.
- `i_ready`  in  1  downstream accepts the word.
- `o_data`  out  `RATIO*IN_W`  packed word; unfilled lanes are 0.
- `o_keep`  out  `RATIO`  bit k=1 means lane k (bits `[k*IN_W +: IN_W]`) holds data.
- `o_last`  out  1  word was closed by `i_last`.

## Operation
- **Accept rule.** A beat is accepted when `i_valid && o_ready`.
- **Ready rule.** `o_ready = (!o_valid || i_ready) && !flush_pend`.
- **Accumulator.** The accumulator holds lane count `cnt`, from 0 to `RATIO-1`.
  - An accepted beat is written to lane `RATIO-1-cnt` when `MSB_FIRST=1`, else to lane `cnt`.
  - Unfilled lanes stay 0.
- **Close condition.** A word closes on the accepting edge when `cnt==RATIO-1` or `i_last=1`. On close:
  - the accumulator contents, including this beat, load the output register;
  - `o_keep` gets the filled lanes;
  - `o_last` gets `i_last`;
  - `o_valid` is set to 1;
  - `cnt` and the accumulator clear.
- **Flush, empty accumulator.** `i_flush` with `cnt==0` and no beat accepted is a no-op.
- **Flush with beat in the same cycle.** `i_flush` together with an accepted beat behaves as `i_last=1` for that beat, except that `o_last` takes the value of `i_last`.
- **Flush with buffered data, no beat.** `i_flush` with `cnt>0` and no accepted beat:
  - if the output register is free or draining (`!o_valid || i_ready`), the partial word loads on that edge with `o_last=0`;
  - otherwise `flush_pend` is set. While it is set, `o_ready=0`. The partial word loads on the first edge where `!o_valid || i_ready`, and `flush_pend` clears on that same edge.
- **Output hold.** `o_valid` is held until `o_valid && i_ready`.
  - `o_data`, `o_keep` and `o_last` are stable while `o_valid && !i_ready`.
  - If the output is consumed and a new word closes on the same edge, `o_valid` stays 1 and the new data is presented.
- **Output clear.** Consumption with no new word clears `o_valid`. `o_data`, `o_keep` and `o_last` keep their last values.

## Timing
- **Reset values.** On `i_rst` (synchronous):
  - `o_valid=0`, `o_data=0`, `o_keep=0`, `o_last=0`;
  - `cnt=0`, accumulator 0, `flush_pend=0`, idle counter 0.
- **Reset mid-word.** Any buffered partial word is discarded.
- **Reset wins.** Reset overrides all simultaneous inputs.
- **Latency.** 1 cycle. `o_valid` rises on the edge after the closing beat or flush is accepted.
- **Throughput.** With `i_ready` held at 1, one beat is accepted per cycle. A full word appears every `RATIO` cycles, with no bubbles.
- **Ready path.** `o_ready` depends combinationally on `i_ready`. No register sits in that path.

## Configuration
- Macro: `BYTE_PACKER_TIMEOUT_EN`.
- **Defined:**
  - An idle counter increments each cycle in which `cnt>0`, no beat is accepted and `flush_pend=0`.
  - It clears on any accepted beat, and whenever `cnt==0`.
  - When it reaches `TIMEOUT_CYC`, it raises an internal flush identical to `i_flush`. The resulting word has `o_last=0`. The counter then clears.
- **Not defined:**
  - No counter logic is built and `TIMEOUT_CYC` is ignored.
  - Partial words leave only via `i_last` or `i_flush`.

## Test plan
- **Full-rate packing.** `RATIO=2`, `MSB_FIRST=1`, `i_ready=1`; beats 0x12, 0x34, 0x56, 0x78 on consecutive cycles.
  - Word 0x1234 with keep=2'b11 one cycle after 0x34.
  - Word 0x5678 with keep=2'b11 one cycle after 0x78.
  - `o_ready` stays 1 throughout.
- **LSB-first partial word.** `RATIO=4`, `MSB_FIRST=0`; beats 0xAA, 0xBB, then 0xCC with `i_last=1`.
  - `o_data=0x00CCBBAA`, `o_keep=4'b0111`, `o_last=1`.
- **Backpressure.** `RATIO=2`; hold `i_ready=0` after the first word.
  - `o_data` is stable and `o_ready=0` while the next word is complete and waiting.
  - Raise `i_ready`: the next beat is accepted the same cycle and no beats are lost or duplicated.
- **Flush cases.** `RATIO=2`, `MSB_FIRST=1`:
  - beat 0x9A, then `i_flush` with the output free → `o_data=0x9A00`, `o_keep=2'b10`, `o_last=0`;
  - `i_flush` with `cnt==0` → no output.
- **Reset mid-word.** Beat 0x11, then `i_rst` for 1 cycle, then beats 0x22, 0x33.
  - The only word is 0x2233; all outputs are 0 in the cycle after reset.
- **Timeout** (`BYTE_PACKER_TIMEOUT_EN`, `TIMEOUT_CYC=4`). Beat 0x5C, then idle.
  - `o_valid` rises 5 cycles after acceptance with `o_data=0x5C00`, `o_keep=2'b10`.
  - With the macro undefined, no output ever appears.
